// File: rtl/ahb_uart_pkg.sv
// Shared definitions for the AHB-Lite UART: register map, bit positions,
// bus transfer codes and the state encoding used by both serial FSMs.
package ahb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_EMPTY  = 2;
  localparam int STAT_RX_FULL   = 3;
  localparam int STAT_OVERRUN   = 4;
  localparam int STAT_FRAME_ERR = 5;
  localparam int STAT_TX_BUSY   = 6;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_TX_IRQ_EN = 2;
  localparam int CTRL_RX_IRQ_EN = 3;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [15:0] MIN_DIV = 16'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Divisors below the minimum would leave too few cycles to centre the RX sample
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a pop on an empty FIFO reads 0, and a push on a full
// FIFO is only accepted when a pop frees the slot in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | pop);
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array; left unreset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ahb_uart.sv
// AHB-Lite zero-wait-state UART slave: 8N1 TX/RX with FIFOs, programmable
// bit period, sticky error flags and one registered level interrupt.
module ahb_uart
  import ahb_uart_pkg::*;
#(
  parameter int          ADDR_WIDTH = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic                  UART_TXD,
  input  logic                  UART_RXD,
  output logic                  IRQ
);

  logic        dp_valid_r, dp_write_r;
  logic [1:0]  dp_addr_r;
  logic [3:0]  ctrl_r;
  logic [15:0] baud_r;
  logic        overrun_r, frame_err_r, irq_r;

  uart_state_e tx_state_r;
  logic [15:0] tx_cnt_r, tx_div_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;
  logic        txd_r;

  uart_state_e rx_state_r;
  logic [15:0] rx_cnt_r, rx_div_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic [1:0]  rx_sync_r;
  logic        rx_prev_r;

  logic        accept_s, wr_s, rd_s, status_wr_s;
  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_busy_s, tx_bit_end_s;
  logic [7:0]  tx_dout_s, rx_dout_s;
  logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic        rxd_s, rx_fall_s, rx_half_s, rx_bit_end_s, rx_stop_s;
  logic        ov_set_s, fe_set_s, irq_next_s;
  logic [31:0] status_s;
  logic        unused_s;

  assign unused_s = ^{HSIZE, HADDR, HWDATA[31:16]};

  assign accept_s    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign wr_s        = dp_valid_r & dp_write_r;
  assign rd_s        = dp_valid_r & ~dp_write_r;
  assign status_wr_s = wr_s & (dp_addr_r == REG_STATUS);
  assign tx_push_s   = wr_s & (dp_addr_r == REG_DATA);
  assign rx_pop_s    = rd_s & (dp_addr_r == REG_DATA);

  assign tx_busy_s    = (tx_state_r != ST_IDLE);
  assign tx_bit_end_s = (tx_cnt_r == tx_div_r - 16'd1);
  // STOP can chain straight into the next START, so both states may pop
  assign tx_pop_s = ctrl_r[CTRL_TX_EN] & ~tx_empty_s &
                    ((tx_state_r == ST_IDLE) | ((tx_state_r == ST_STOP) & tx_bit_end_s));

  assign rxd_s        = rx_sync_r[1];
  assign rx_fall_s    = rx_prev_r & ~rxd_s;
  assign rx_half_s    = (rx_cnt_r == {1'b0, rx_div_r[15:1]});
  assign rx_bit_end_s = (rx_cnt_r == rx_div_r - 16'd1);
  assign rx_stop_s    = ctrl_r[CTRL_RX_EN] & (rx_state_r == ST_STOP) & rx_bit_end_s;
  assign rx_push_s    = rx_stop_s & rxd_s;
  assign fe_set_s     = rx_stop_s & ~rxd_s;
  assign ov_set_s     = rx_push_s & rx_full_s & ~rx_pop_s;

  assign status_s = {25'd0, tx_busy_s, frame_err_r, overrun_r,
                     rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};

  assign irq_next_s = (ctrl_r[CTRL_TX_IRQ_EN] & tx_empty_s & ~tx_busy_s) |
                      (ctrl_r[CTRL_RX_IRQ_EN] & (~rx_empty_s | overrun_r | frame_err_r));

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign UART_TXD  = txd_r;
  assign IRQ       = irq_r;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(tx_push_s), .pop(tx_pop_s),
    .din(HWDATA[7:0]), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(rx_push_s), .pop(rx_pop_s),
    .din(rx_shift_r), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  // Read mux, driven from the address captured in the previous cycle
  always_comb begin
    HRDATA = 32'd0;
    if (rd_s) begin
      case (dp_addr_r)
        REG_DATA:   HRDATA = {24'd0, rx_dout_s};
        REG_STATUS: HRDATA = status_s;
        REG_CTRL:   HRDATA = {28'd0, ctrl_r};
        REG_BAUD:   HRDATA = {16'd0, baud_r};
        default:    HRDATA = 32'd0;
      endcase
    end else begin
      HRDATA = 32'd0;
    end
  end

  // Bus address-phase capture, control registers, sticky flags and IRQ
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_r  <= 1'b0;
      dp_write_r  <= 1'b0;
      dp_addr_r   <= 2'd0;
      ctrl_r      <= 4'd0;
      baud_r      <= DIV_RESET;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      dp_valid_r <= accept_s;
      if (accept_s) begin
        dp_write_r <= HWRITE;
        dp_addr_r  <= HADDR[3:2];
      end
      if (wr_s) begin
        case (dp_addr_r)
          REG_CTRL: ctrl_r <= HWDATA[3:0];
          REG_BAUD: baud_r <= clamp_div(HWDATA[15:0]);
          default:  ctrl_r <= ctrl_r;
        endcase
      end
      // A set from the receiver outranks a same-cycle write-1-clear
      if (ov_set_s)                             overrun_r <= 1'b1;
      else if (status_wr_s & HWDATA[STAT_OVERRUN]) overrun_r <= 1'b0;
      if (fe_set_s)                               frame_err_r <= 1'b1;
      else if (status_wr_s & HWDATA[STAT_FRAME_ERR]) frame_err_r <= 1'b0;
      irq_r <= irq_next_s;
    end
  end

  // Transmitter: 8N1, LSB first, each bit held for the latched divisor
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_div_r   <= MIN_DIV;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      txd_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          txd_r <= tx_pop_s ? 1'b0 : 1'b1;
          if (tx_pop_s) begin
            tx_state_r <= ST_START;
            tx_shift_r <= tx_dout_s;
            tx_div_r   <= baud_r;
            tx_cnt_r   <= 16'd0;
          end
        end
        ST_START: begin
          if (tx_bit_end_s) begin
            tx_state_r <= ST_DATA;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            txd_r      <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_bit_end_s) begin
            tx_cnt_r <= 16'd0;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= ST_STOP;
              txd_r      <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              txd_r      <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_bit_end_s) begin
            tx_cnt_r <= 16'd0;
            if (tx_pop_s) begin
              tx_state_r <= ST_START;
              tx_shift_r <= tx_dout_s;
              tx_div_r   <= baud_r;
              txd_r      <= 1'b0;
            end else begin
              tx_state_r <= ST_IDLE;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        default: begin
          tx_state_r <= ST_IDLE;
          txd_r      <= 1'b1;
        end
      endcase
    end
  end

  // Receiver: synchronise RXD, validate start at mid-bit, sample each bit centre
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_sync_r  <= 2'b11;
      rx_prev_r  <= 1'b1;
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_div_r   <= MIN_DIV;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rx_sync_r <= {rx_sync_r[0], UART_RXD};
      rx_prev_r <= rxd_s;
      if (!ctrl_r[CTRL_RX_EN]) begin
        rx_state_r <= ST_IDLE;
        rx_cnt_r   <= 16'd0;
      end else begin
        case (rx_state_r)
          ST_IDLE: begin
            rx_cnt_r <= 16'd0;
            if (rx_fall_s) begin
              rx_state_r <= ST_START;
              rx_div_r   <= baud_r;
            end
          end
          ST_START: begin
            if (rx_half_s) begin
              rx_cnt_r   <= 16'd0;
              rx_bit_r   <= 3'd0;
              rx_state_r <= rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt_r <= rx_cnt_r + 16'd1;
            end
          end
          ST_DATA: begin
            if (rx_bit_end_s) begin
              rx_cnt_r   <= 16'd0;
              rx_shift_r <= {rxd_s, rx_shift_r[7:1]};
              rx_bit_r   <= rx_bit_r + 3'd1;
              if (rx_bit_r == 3'd7) rx_state_r <= ST_STOP;
            end else begin
              rx_cnt_r <= rx_cnt_r + 16'd1;
            end
          end
          ST_STOP: begin
            if (rx_bit_end_s) begin
              rx_cnt_r   <= 16'd0;
              rx_state_r <= ST_IDLE;
            end else begin
              rx_cnt_r <= rx_cnt_r + 16'd1;
            end
          end
          default: rx_state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
